memory_loader: RTL and testbench
================================

# memory_loader

Boot-time initiator for the unified Memory data port. It accepts a byte stream (from the UART/debug front end), packs it little-endian into 32-bit words and writes them to consecutive word addresses using WORD mode. Optionally it reads each word back and checks it. It holds the CPU off the memory while running, then releases it, so it replaces manual testbench preloading on hardware.

## Interface
Parameters:
- BASE_ADDR, 32'd0, byte address of the first word written; must be word-aligned.
- VERIFY, 1, 1 = read back and compare every word after writing it; 0 = write only.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- startLoad  input  1  one-cycle pulse that begins a load; sampled only in IDLE and DONE.
- wordCount  input  16  number of words to load; latched on startLoad.
- byteData  input  8  incoming stream byte.
- byteValid  input  1  byteData is valid this cycle.
- byteReady  output  1  loader accepts a byte this cycle; a transfer occurs when byteValid and byteReady are both 1.
- address  output  32  Memory address.
- data  output  32  Memory write data.
- writeMode  output  3  MemoryModesPackage mode; only WORD or ReadWriteMode_NONE is ever driven.
- readMode  output  3  MemoryModesPackage mode; only WORD or ReadWriteMode_NONE is ever driven.
- unsignedLoad  output  1  held at 0.
- dataOutput  input  32  Memory read data.
- busy  output  1  a load is in progress.
- cpuHold  output  1  CPU must not drive memory or advance its PC; equals busy.
- done  output  1  last load completed.
- verifyError  output  1  sticky flag: a readback mismatch occurred in the current load.
- errorAddress  output  32  address of the first mismatching word.

## Operation
- States: IDLE, COLLECT, WRITE, RDBACK, CHECK, DONE.
- IDLE / DONE, startLoad=1:
  - clear wordIdx, byteIdx, verifyError and errorAddress; latch wordCount.
  - wordCount==0: go to DONE.
  - otherwise: go to COLLECT.
- COLLECT:
  - byteReady=1; each accepted byte goes to word bits [8*byteIdx+7 : 8*byteIdx], and byteIdx increments mod 4.
  - byteIdx 0 holds the least significant byte, so bytes 78,56,34,12 form 32'h12345678.
  - on acceptance of the 4th byte: go to WRITE.
- WRITE (1 cycle):
  - address = BASE_ADDR + 4*wordIdx (mod 2^32); data = packed word; writeMode=WORD.
  - next state is RDBACK if VERIFY=1, otherwise ADVANCE.
- RDBACK (1 cycle): same address; readMode=WORD; writeMode=NONE.
- CHECK (1 cycle):
  - address and readMode are held; dataOutput is compared with the packed word.
  - on mismatch with verifyError=0: set verifyError and capture errorAddress. Later mismatches keep the first address.
  - then ADVANCE.
- ADVANCE (folded into the WRITE/CHECK exit, not a separate state):
  - wordIdx++.
  - wordIdx==latched count: go to DONE.
  - otherwise: go to COLLECT.
- DONE: done=1 and busy=0. Stays in DONE until the next startLoad; done clears on leaving.
- Outside WRITE, RDBACK and CHECK: writeMode=readMode=ReadWriteMode_NONE, and address=data=0.
- byteReady=0 in every state except COLLECT. Bytes offered there are not consumed (sender holds them).
- startLoad while busy is ignored; wordCount changes after the latch are ignored.

## Timing
- Reset values (all outputs): 0, except writeMode=readMode=ReadWriteMode_NONE. State is IDLE.
- Reset asserted mid-load: immediate return to IDLE. Partially packed bytes and the word counter are discarded, and memory is not written further.
- Memory writes commit on the rising edge at the end of WRITE.
- Memory read data is valid after the rising edge ending RDBACK and is sampled in CHECK.
- Per word, with a byte offered every cycle: 4 COLLECT + 1 WRITE, plus 2 (RDBACK, CHECK) if VERIFY. That is 5 cycles (VERIFY=0) or 7 cycles (VERIFY=1).
- Load of N words: startLoad to done = 1 + 7N cycles (VERIFY=1); busy rises on the cycle after startLoad.
- Stalls on byteValid=0 only extend COLLECT; the other states are fixed length.
- Address wraps modulo 2^32; wordIdx (16 bits) never exceeds the latched count.

## Test plan
- Reset with rst=0 mid-COLLECT -> all outputs at reset values; the next startLoad writes its first word at BASE_ADDR.
- VERIFY=1, wordCount=5, bytes forming 0,1,2,3,4 -> Memory pcDataOutput at pcAddress 0,4,8,12,16 reads 0..4; done after 36 cycles; verifyError=0.
- Bytes 78,56,34,12 with stalls (byteValid low 3 cycles between bytes) -> word 32'h12345678 at BASE_ADDR; WRITE occurs exactly once.
- Bench forces dataOutput to 32'hDEADBEEF during CHECK of word 2 (of 4) -> verifyError=1, errorAddress=BASE_ADDR+8; the load still completes, and later mismatches don't change errorAddress.
- wordCount=0 -> DONE on the next cycle; no writeMode=WORD ever driven; byteReady stays 0.
- startLoad pulsed while busy, and wordCount changed mid-load -> both ignored; the original count is written.

Source files
------------

// File: rtl/memory_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words, writes them
// to consecutive word addresses and optionally reads each one back to verify it.
module memory_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startLoad,
    input  logic [15:0] wordCount,
    input  logic [7:0]  byteData,
    input  logic        byteValid,
    output logic        byteReady,
    output logic [31:0] address,
    output logic [31:0] data,
    output logic [2:0]  writeMode,
    output logic [2:0]  readMode,
    output logic        unsignedLoad,
    input  logic [31:0] dataOutput,
    output logic        busy,
    output logic        cpuHold,
    output logic        done,
    output logic        verifyError,
    output logic [31:0] errorAddress
);

    // Encodings shared with the memory's read/write mode definitions.
    localparam logic [2:0] RW_NONE = 3'd0;
    localparam logic [2:0] RW_WORD = 3'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        RDBACK  = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state_r;
    logic [31:0] word_r;
    logic [1:0]  byte_idx_r;
    logic [15:0] word_idx_r;
    logic [15:0] count_r;
    logic [15:0] next_idx_s;
    logic        last_word_s;

    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return BASE_ADDR + {14'd0, idx, 2'b00};
    endfunction

    assign unsignedLoad = 1'b0;

    // Word-index advance shared by the WRITE and CHECK exits.
    always_comb begin
        next_idx_s  = word_idx_r + 16'd1;
        last_word_s = 1'b0;
        if (next_idx_s == count_r) begin
            last_word_s = 1'b1;
        end else begin
            last_word_s = 1'b0;
        end
    end

    // Loader FSM with all memory-side outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            word_r       <= 32'd0;
            byte_idx_r   <= 2'd0;
            word_idx_r   <= 16'd0;
            count_r      <= 16'd0;
            byteReady    <= 1'b0;
            address      <= 32'd0;
            data         <= 32'd0;
            writeMode    <= RW_NONE;
            readMode     <= RW_NONE;
            busy         <= 1'b0;
            cpuHold      <= 1'b0;
            done         <= 1'b0;
            verifyError  <= 1'b0;
            errorAddress <= 32'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (startLoad) begin
                        word_idx_r   <= 16'd0;
                        byte_idx_r   <= 2'd0;
                        verifyError  <= 1'b0;
                        errorAddress <= 32'd0;
                        count_r      <= wordCount;
                        if (wordCount == 16'd0) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r   <= COLLECT;
                            done      <= 1'b0;
                            byteReady <= 1'b1;
                            busy      <= 1'b1;
                            cpuHold   <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (byteValid) begin
                        word_r[{byte_idx_r, 3'b000} +: 8] <= byteData;
                        byte_idx_r <= byte_idx_r + 2'd1;
                        // The 4th byte goes straight onto the data bus together with the first three.
                        if (byte_idx_r == 2'd3) begin
                            state_r   <= WRITE;
                            byteReady <= 1'b0;
                            address   <= word_addr(word_idx_r);
                            data      <= {byteData, word_r[23:0]};
                            writeMode <= RW_WORD;
                        end
                    end
                end
                WRITE: begin
                    writeMode <= RW_NONE;
                    if (VERIFY) begin
                        state_r  <= RDBACK;
                        readMode <= RW_WORD;
                    end else begin
                        word_idx_r <= next_idx_s;
                        address    <= 32'd0;
                        data       <= 32'd0;
                        if (last_word_s) begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            cpuHold <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r   <= COLLECT;
                            byteReady <= 1'b1;
                        end
                    end
                end
                RDBACK: begin
                    state_r <= CHECK;
                end
                CHECK: begin
                    // Only the first mismatch of a load records its address.
                    if ((dataOutput != word_r) && !verifyError) begin
                        verifyError  <= 1'b1;
                        errorAddress <= address;
                    end
                    readMode   <= RW_NONE;
                    word_idx_r <= next_idx_s;
                    address    <= 32'd0;
                    data       <= 32'd0;
                    if (last_word_s) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        cpuHold <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r   <= COLLECT;
                        byteReady <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    byteReady <= 1'b0;
                    writeMode <= RW_NONE;
                    readMode  <= RW_NONE;
                    busy      <= 1'b0;
                    cpuHold   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
// Self-checking bench for memory_loader: a word-array memory model, a write log and
// expected words/addresses/timing computed from the byte stream each load sends.
module tb_memory_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [2:0]  NONE = 3'd0;
    localparam logic [2:0]  WORD = 3'd3;

    logic        clk, rst, startLoad, byteValid, byteReady, unsignedLoad;
    logic [15:0] wordCount;
    logic [7:0]  byteData;
    logic [31:0] address, data, dataOutput, errorAddress;
    logic [2:0]  writeMode, readMode;
    logic        busy, cpuHold, done, verifyError;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    bit          bad [0:255];
    logic [31:0] rd_q;
    logic [63:0] wlog [$];

    memory_loader #(.BASE_ADDR(BASE), .VERIFY(1'b1)) dut (
        .clk(clk), .rst(rst), .startLoad(startLoad), .wordCount(wordCount),
        .byteData(byteData), .byteValid(byteValid), .byteReady(byteReady),
        .address(address), .data(data), .writeMode(writeMode), .readMode(readMode),
        .unsignedLoad(unsignedLoad), .dataOutput(dataOutput), .busy(busy),
        .cpuHold(cpuHold), .done(done), .verifyError(verifyError),
        .errorAddress(errorAddress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned widx(input logic [31:0] a);
        return ((a - BASE) >> 2) & 32'd255;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: word writes land in mem, word reads return one edge later.
    assign dataOutput = rd_q;
    always @(posedge clk) begin
        if (readMode === WORD)
            rd_q <= bad[widx(address)] ? 32'hDEAD_BEEF : mem[widx(address)];
        if (rst === 1'b1 && writeMode === WORD) begin
            mem[widx(address)] <= data;
            wlog.push_back({address, data});
        end
    end

    // Output-relationship invariants checked every cycle.
    always @(negedge clk) begin
        check("cpuHold_eq_busy", 64'(cpuHold), 64'(busy));
        check("unsignedLoad_zero", 64'(unsignedLoad), 64'(0));
        if (byteReady === 1'b1) begin
            check("ready_only_collect_wm", 64'(writeMode), 64'(NONE));
            check("ready_only_collect_rm", 64'(readMode), 64'(NONE));
        end
        if (writeMode === NONE && readMode === NONE)
            check("idle_bus_zero", {address, data}, 64'(0));
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byteReady"}, 64'(byteReady), 64'(0));
        check({tag, "_addr_data"}, {address, data}, 64'(0));
        check({tag, "_writeMode"}, 64'(writeMode), 64'(NONE));
        check({tag, "_readMode"}, 64'(readMode), 64'(NONE));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_verifyError"}, 64'(verifyError), 64'(0));
        check({tag, "_errorAddress"}, 64'(errorAddress), 64'(0));
    endtask

    // dmode: 0 random words, 1 word k = k, 2 fixed 32'h12345678.
    // smode: 0 byte every cycle, 1 random stalls, 2 three idle cycles after each byte.
    task automatic run_load(input int n, input int dmode, input int smode, input bit poke);
        logic [31:0] words [$];
        logic [7:0]  bytes [$];
        logic [31:0] w, a, exp_err_addr;
        bit          exp_err, xfer;
        int          edges, gap, it;
        for (int k = 0; k < n; k++) begin
            w = (dmode == 0) ? $urandom : (dmode == 1) ? 32'(k) : 32'h1234_5678;
            words.push_back(w);
            for (int b = 0; b < 4; b++) bytes.push_back(8'((w >> (8 * b)) & 32'hFF));
        end
        exp_err = 1'b0;
        exp_err_addr = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = BASE + 32'(4 * k);
            if (bad[widx(a)] && !exp_err) begin
                exp_err = 1'b1;
                exp_err_addr = a;
            end
        end
        wlog.delete();
        startLoad = 1'b1;
        wordCount = 16'(n);
        @(posedge clk); #1;
        startLoad = 1'b0;
        wordCount = 16'($urandom);
        edges = 1; gap = 0; it = 0;
        forever begin
            if (bytes.size() > 0 && gap == 0 && !(smode == 1 && $urandom_range(0, 2) == 0)) begin
                byteValid = 1'b1;
                byteData  = bytes[0];
            end else begin
                byteValid = 1'b0;
                byteData  = 8'($urandom);
            end
            if (poke && it == 6) begin
                startLoad = 1'b1;
                wordCount = 16'(n + 7);
            end else begin
                startLoad = 1'b0;
            end
            @(negedge clk);
            xfer = byteValid && byteReady;
            if (done === 1'b1) break;
            if (it >= 3000) begin
                check("load_finished", 64'(done), 64'(1));
                break;
            end
            @(posedge clk); #1;
            edges++; it++;
            if (xfer) begin
                void'(bytes.pop_front());
                if (smode == 2) gap = 3;
            end else if (gap > 0) begin
                gap--;
            end
        end
        byteValid = 1'b0;
        startLoad = 1'b0;
        check("bytes_consumed", 64'(bytes.size()), 64'(0));
        check("done_busy_ready", {61'd0, done, busy, byteReady}, 64'(4));
        check("write_count", 64'(wlog.size()), 64'(n));
        for (int k = 0; k < n && k < wlog.size(); k++) begin
            check($sformatf("write_%0d", k), wlog[k], {BASE + 32'(4 * k), words[k]});
            check($sformatf("mem_%0d", k), 64'(mem[widx(BASE + 32'(4 * k))]), 64'(words[k]));
        end
        check("verifyError", 64'(verifyError), 64'(exp_err));
        check("errorAddress", 64'(errorAddress), 64'(exp_err_addr));
        if (smode == 0) check("load_cycles", 64'(edges), 64'(1 + 7 * n));
    endtask

    initial begin
        rst = 1'b0; startLoad = 1'b0; wordCount = 16'd0;
        byteData = 8'd0; byteValid = 1'b0; rd_q = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'd0;
            bad[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Zero-word load: DONE on the next edge, nothing written.
        wlog.delete();
        startLoad = 1'b1; wordCount = 16'd0;
        @(posedge clk); #1;
        startLoad = 1'b0;
        @(negedge clk);
        check("zero_done", {62'd0, done, busy}, 64'(2));
        repeat (4) begin
            @(negedge clk);
            check("zero_ready", 64'(byteReady), 64'(0));
        end
        check("zero_no_write", 64'(wlog.size()), 64'(0));
        @(posedge clk); #1;

        run_load(5, 1, 0, 1'b0);
        run_load(1, 2, 2, 1'b0);

        bad[2] = 1'b1; bad[3] = 1'b1;
        run_load(4, 0, 0, 1'b0);
        bad[2] = 1'b0; bad[3] = 1'b0;

        run_load(3, 0, 1, 1'b1);
        run_load(6, 0, 1, 1'b0);

        // Reset in the middle of COLLECT, three bytes into the first word.
        @(posedge clk); #1;
        wlog.delete();
        startLoad = 1'b1; wordCount = 16'd3;
        @(posedge clk); #1;
        startLoad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            byteValid = 1'b1; byteData = 8'($urandom);
            @(posedge clk); #1;
        end
        byteValid = 1'b0;
        check("mid_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        check("midreset_no_write", 64'(wlog.size()), 64'(0));
        @(posedge clk); #1;
        run_load(2, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
